// File: rtl/packet_ingest.sv
// packet_ingest: writes a stream packet into the packet RAM from address 0.
// It reports the packet length in bytes and holds the buffer until the
// filter releases it with pkt_done. Packets larger than the RAM are dropped.
// Optional feature macro: PACKET_INGEST_DROP_CNT_EN builds a saturating
// counter of dropped packets. Without it, drop_cnt is tied to 0.
module packet_ingest #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_en,
    output logic                    pkt_ready,
    output logic [ADDR_WIDTH+2:0]   pkt_len,
    input  logic                    pkt_done,
    output logic [31:0]             drop_cnt
);

    localparam int LEN_W = ADDR_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] WORD_MAX = '1;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] word_cnt_reg, word_cnt_next;
    logic                  pkt_ready_reg, pkt_ready_next;
    logic [LEN_W-1:0]      pkt_len_reg, pkt_len_next;
    logic [2:0]            keep_ext [4];
    logic [2:0]            keep_ones;
    logic                  beat_acc;

    // Each keep bit is widened to 3 bits so the four can be summed.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_keep
            assign keep_ext[gi] = {2'b00, s_tkeep[gi]};
        end
    endgenerate
    assign keep_ones = keep_ext[0] + keep_ext[1] + keep_ext[2] + keep_ext[3];

    // The ready signal depends only on the state, so s_tvalid has no path to it.
    // The RAM write port is driven directly by the handshake.
    assign s_tready  = (state_reg != HOLD);
    assign beat_acc  = s_tvalid & s_tready;
    assign wr_en     = beat_acc & (state_reg == RECV);
    assign wr_addr   = word_cnt_reg;
    assign wr_data   = s_tdata;
    assign pkt_ready = pkt_ready_reg;
    assign pkt_len   = pkt_len_reg;

    // Register the state, the word counter and the packet result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RECV;
            word_cnt_reg  <= '0;
            pkt_ready_reg <= 1'b0;
            pkt_len_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            pkt_ready_reg <= pkt_ready_next;
            pkt_len_reg   <= pkt_len_next;
        end
    end

    // Compute the next state and update the counter and the length.
    always_comb begin
        state_next     = state_reg;
        word_cnt_next  = word_cnt_reg;
        pkt_ready_next = pkt_ready_reg;
        pkt_len_next   = pkt_len_reg;
        case (state_reg)
            RECV: begin
                if (beat_acc) begin
                    word_cnt_next = word_cnt_reg + 1'b1;
                    if (s_tlast) begin
                        // 4*DEPTH is the largest length and fits in LEN_W bits.
                        pkt_len_next   = LEN_W'({word_cnt_reg, 2'b00}) + LEN_W'(keep_ones);
                        pkt_ready_next = 1'b1;
                        state_next     = HOLD;
                    end else if (word_cnt_reg == WORD_MAX) begin
                        // RAM is full and the packet continues, so it cannot fit.
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (beat_acc && s_tlast) begin
                    word_cnt_next = '0;
                    state_next    = RECV;
                end
            end
            HOLD: begin
                if (pkt_done) begin
                    pkt_ready_next = 1'b0;
                    word_cnt_next  = '0;
                    state_next     = RECV;
                end
            end
            default: state_next = RECV;
        endcase
    end

`ifdef PACKET_INGEST_DROP_CNT_EN
    logic [31:0] drop_cnt_reg;
    logic        drop_event;

    assign drop_event = (state_reg == DROP) & beat_acc & s_tlast;

    // Count one drop for each DROP-to-RECV exit. The counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (drop_event && (drop_cnt_reg != 32'hFFFF_FFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end
    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_packet_ingest.sv
// tb_packet_ingest: directed test of packet_ingest with ADDR_WIDTH=2 (a 4-word RAM).
// Every expected value below is worked out by hand from the behaviour of the block.
module tb_packet_ingest;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_tdata = '0;
    logic [3:0]    s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic          pkt_ready;
    logic [AW+2:0] pkt_len;
    logic          pkt_done = 1'b0;
    logic [31:0]   drop_cnt;

    int checks = 0;
    int failures = 0;

`ifdef PACKET_INGEST_DROP_CNT_EN
    localparam logic [31:0] EXP_DROPS = 32'd1;
`else
    localparam logic [31:0] EXP_DROPS = 32'd0;
`endif

    packet_ingest #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .pkt_ready(pkt_ready),
        .pkt_len  (pkt_len),
        .pkt_done (pkt_done),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Compare a value with its expected value, count the check and report any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Send one beat: drive it after the falling edge and check the write port.
    // Then let the rising edge capture it and sample the outputs 1 ns later.
    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic exp_we, input logic [31:0] exp_addr);
        @(negedge clk);
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        #1;
        check("wr_en", {31'd0, wr_en}, {31'd0, exp_we});
        if (exp_we) begin
            check("wr_addr", {30'd0, wr_addr}, exp_addr);
            check("wr_data", wr_data, d);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    // Run one idle cycle with s_tvalid low. No write may occur.
    task automatic idle();
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Pulse pkt_done for one cycle, then check the ready flags.
    task automatic done_pulse(input logic exp_ready_after);
        @(negedge clk);
        pkt_done = 1'b1;
        @(posedge clk); #1;
        pkt_done = 1'b0;
        check("done_pkt_ready", {31'd0, pkt_ready}, {31'd0, exp_ready_after});
        check("done_s_tready", {31'd0, s_tready}, 32'd1);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_s_tready", {31'd0, s_tready}, 32'd1);
        check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        check("rst_pkt_len", {27'd0, pkt_len}, 32'd0);
        check("rst_drop_cnt", drop_cnt, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {30'd0, wr_addr}, 32'd0);

        // Three beats with keep 1100 on the last beat: 2*4 + 2 = 10 bytes.
        beat(32'h11223344, 4'b0000, 1'b0, 1'b1, 0);
        beat(32'h55667788, 4'b0000, 1'b0, 1'b1, 1);
        beat(32'h99AABBCC, 4'b1100, 1'b1, 1'b1, 2);
        check("p1_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("p1_pkt_len", {27'd0, pkt_len}, 32'd10);
        check("p1_s_tready", {31'd0, s_tready}, 32'd0);
        // In HOLD, a valid beat is not accepted and nothing is written.
        beat(32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, 0);
        check("hold_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("hold_pkt_len", {27'd0, pkt_len}, 32'd10);
        done_pulse(1'b0);

        // One beat with keep 1111 is 4 bytes, written at address 0.
        beat(32'hDEADBEEF, 4'b1111, 1'b1, 1'b1, 0);
        check("p2_pkt_len", {27'd0, pkt_len}, 32'd4);
        done_pulse(1'b0);

        // A packet of exactly DEPTH words is accepted: 16 bytes.
        beat(32'hA0000000, 4'b0000, 1'b0, 1'b1, 0);
        beat(32'hA0000001, 4'b0000, 1'b0, 1'b1, 1);
        beat(32'hA0000002, 4'b0000, 1'b0, 1'b1, 2);
        beat(32'hA0000003, 4'b1111, 1'b1, 1'b1, 3);
        check("full_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("full_pkt_len", {27'd0, pkt_len}, 32'd16);
        done_pulse(1'b0);

        // Six beats: four writes, then DROP. pkt_done in DROP has no effect.
        for (int i = 0; i < 4; i++) beat(32'hB0000000 + i, 4'b0000, 1'b0, 1'b1, i);
        beat(32'hB0000004, 4'b0000, 1'b0, 1'b0, 0);
        done_pulse(1'b0);
        beat(32'hB0000005, 4'b1111, 1'b1, 1'b0, 0);
        check("drop_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        check("drop_cnt", drop_cnt, EXP_DROPS);
        // The next packet starts at address 0: keep 0001 gives 1 byte.
        beat(32'hC0000000, 4'b0001, 1'b1, 1'b1, 0);
        check("afterdrop_pkt_len", {27'd0, pkt_len}, 32'd1);
        done_pulse(1'b0);

        // pkt_done in RECV mid-packet leaves word_cnt unchanged: 4 + 2 = 6 bytes.
        beat(32'hD0000000, 4'b0000, 1'b0, 1'b1, 0);
        done_pulse(1'b0);
        beat(32'hD0000001, 4'b1010, 1'b1, 1'b1, 1);
        check("recvdone_pkt_len", {27'd0, pkt_len}, 32'd6);
        done_pulse(1'b0);

        // Gaps in s_tvalid keep the addresses contiguous: 8 + 3 = 11 bytes.
        beat(32'hE0000000, 4'b0000, 1'b0, 1'b1, 0);
        idle();
        beat(32'hE0000001, 4'b0000, 1'b0, 1'b1, 1);
        idle();
        beat(32'hE0000002, 4'b1110, 1'b1, 1'b1, 2);
        check("gap_pkt_len", {27'd0, pkt_len}, 32'd11);
        done_pulse(1'b0);

        // Reset after two of four beats. The reset is asynchronous, so check before any clock edge.
        beat(32'hF0000000, 4'b0000, 1'b0, 1'b1, 0);
        beat(32'hF0000001, 4'b0000, 1'b0, 1'b1, 1);
        @(negedge clk); rst = 1'b1;
        #1;
        check("arst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        check("arst_s_tready", {31'd0, s_tready}, 32'd1);
        check("arst_wr_addr", {30'd0, wr_addr}, 32'd0);
        check("arst_drop_cnt", drop_cnt, 32'd0);
        @(negedge clk); rst = 1'b0;
        beat(32'h12345678, 4'b0111, 1'b1, 1'b1, 0);
        check("fresh_pkt_len", {27'd0, pkt_len}, 32'd3);
        check("fresh_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        done_pulse(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
